uc_seq: RTL
===========

Name: uc_seq

Overview:
- Parametrised successor control unit for the single-cycle CPU with I/O. Decodes the 6-bit opcode into datapath controls.
- Adds registered sequential behaviour: a multi-instruction skip counter, a stalling I/O handshake with timeout, and a call-depth tracker with overflow/underflow guards.
- Sits between the instruction memory opcode field, the flag registers (z, n) and the datapath/PC/stack/IO ports.

Parameters:
- SKIP_LEN, 1, number of instructions annulled after a taken skz/sknz; 0 makes skip a NOP.
- STACK_DEPTH, 8, return-stack entries tracked by the call-depth counter.
- IO_TIMEOUT, 255, maximum IO_WAIT cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  current instruction opcode.
- s_z, s_n  in  1 each  zero and negative flags.
- io_ready  in  1  peripheral ready/ack.
- s_inc  out  1  1 = PC+1, 0 = jump/return target.
- s_inm  out  1  register-file write source is the immediate.
- s_in  out  1  register-file write source is the I/O input.
- we3, wez, wen  out  1 each  register-file write, z-flag write, n-flag write.
- wesp, push, pop  out  1 each  stack write enable and direction.
- pc_en  out  1  PC update enable (0 = stall).
- io_rd, io_wr  out  1 each  I/O read/write request.
- op_alu  out  3  ALU operation.
- skipping  out  1  high in the SKIP state.
- stk_ovf, stk_unf, io_timeout  out  1 each  sticky error flags.

Behaviour:
- Decode:
  - 0xxxxx: ALU; op_alu=opcode[4:2]; we3=wez=wen=1.
  - 10xxxx: load immediate; s_inm=we3=1.
  - 110000: j (s_inc=0).
  - 110001: jz, taken if s_z=1.
  - 110010: jnz, taken if s_z=0.
  - 110011: jn, taken if s_n=1.
  - 110100: call; s_inc=0, push=wesp=1.
  - 110101: ret; s_inc=0, pop=wesp=1.
  - 110110: skz.
  - 110111: sknz.
  - 111000: in.
  - 111001: out.
  - All other opcodes: NOP.
- Defaults: s_inc=1, pc_en=1, all other strobes 0. op_alu holds its last value and is 0 after reset.
- Outputs are combinational from state, opcode and flags. State and counters are registered.
- Reset: while reset=1, every output is 0 (including pc_en and s_inc). Next state is RUN; skip_cnt, sp_cnt, io_cnt and all sticky flags clear. Reset aborts a SKIP or IO_WAIT in progress.
- FSM states: RUN, SKIP, IO_WAIT.
- RUN, skip: a taken skz/sknz behaves as a NOP this cycle. If SKIP_LEN>0, go to SKIP with skip_cnt=SKIP_LEN. A not-taken skip, or SKIP_LEN=0, stays in RUN.
- SKIP state:
  - skipping=1, s_inc=1, pc_en=1; every write, stack and IO strobe is 0, whatever the opcode (jumps, calls and I/O are annulled).
  - skip_cnt decrements each cycle; when skip_cnt==1, go to RUN.
- Call-depth counter sp_cnt (0..STACK_DEPTH):
  - call with sp_cnt<STACK_DEPTH: sp_cnt+1.
  - ret with sp_cnt>0: sp_cnt-1.
  - call at full: push/wesp suppressed, s_inc=1 (NOP), stk_ovf set.
  - ret at empty: pop/wesp suppressed, s_inc=1, stk_unf set.
- I/O:
  - in/out in RUN with io_ready=1: completes in one cycle. io_rd (in) or io_wr (out) pulses; for in, s_in=we3=1.
  - in/out in RUN with io_ready=0: request asserted, pc_en=0, no writes; go to IO_WAIT with io_cnt=1.
- IO_WAIT state:
  - Request held, pc_en=0, we3=0.
  - On io_ready=1: complete as above (pc_en=1, for in s_in=we3=1), go to RUN.
  - If IO_TIMEOUT>0 and io_cnt==IO_TIMEOUT with io_ready=0: set io_timeout, pc_en=1, no write, go to RUN.
  - Otherwise io_cnt+1.
- Sticky flags clear only on reset.

Decomposition:
- Package uc_pkg holds:
  - opcode localparams (OP_J, OP_JZ, OP_JNZ, OP_JN, OP_CALL, OP_RET, OP_SKZ, OP_SKNZ, OP_IN, OP_OUT);
  - the state enum {RUN, SKIP, IO_WAIT};
  - the control-bundle struct.
- One sub-module, uc_decode: a purely combinational opcode/flag-to-control-bundle decoder.
- The top level owns the FSM, the counters and the suppression/override logic.

Test Plan:
- Reset, then ALU opcode 000100: op_alu=001, we3=wez=wen=1, pc_en=1. Assert reset mid-operation: all outputs 0 in that cycle.
- SKIP_LEN=2, skz with s_z=1, followed by j and call: skipping=1 for 2 cycles with s_inc=1 and push=0, then RUN. With s_z=0: no skip.
- STACK_DEPTH=2: three calls give push on calls 1-2 and none on call 3, stk_ovf=1, s_inc=1. Then three rets give 2 pops and stk_unf=1.
- in with io_ready=0 for 3 cycles, then 1: pc_en=0 and io_rd=1 for 3 cycles; on the 4th cycle we3=s_in=1, pc_en=1.
- IO_TIMEOUT=4, out with io_ready never high: io_wr held 4 cycles, io_timeout=1, pc_en=1 on abort, RUN next; flag stays 1 until reset.
- Jumps: jz with s_z=1 gives s_inc=0; jn with s_n=0 gives s_inc=1; j gives s_inc=0; undefined opcode 111111 acts as a NOP.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared opcode constants, FSM state type and control bundle for the uc_seq control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uc_pkg;

    localparam logic [5:0] OP_J    = 6'b110000;
    localparam logic [5:0] OP_JZ   = 6'b110001;
    localparam logic [5:0] OP_JNZ  = 6'b110010;
    localparam logic [5:0] OP_JN   = 6'b110011;
    localparam logic [5:0] OP_CALL = 6'b110100;
    localparam logic [5:0] OP_RET  = 6'b110101;
    localparam logic [5:0] OP_SKZ  = 6'b110110;
    localparam logic [5:0] OP_SKNZ = 6'b110111;
    localparam logic [5:0] OP_IN   = 6'b111000;
    localparam logic [5:0] OP_OUT  = 6'b111001;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SKIP    = 2'd1,
        IO_WAIT = 2'd2
    } state_t;

    // Datapath strobes plus the instruction-class tags the sequencer needs
    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       s_in;
        logic       we3;
        logic       wez;
        logic       wen;
        logic       wesp;
        logic       push;
        logic       pop;
        logic       io_rd;
        logic       io_wr;
        logic       alu_vld;
        logic [2:0] op_alu;
        logic       is_call;
        logic       is_ret;
        logic       is_skip;
        logic       is_in;
        logic       is_out;
    } ctrl_t;

    // Bundle for an instruction that does nothing but advance the PC
    function automatic ctrl_t ctrl_nop();
        ctrl_t c;
        c       = '0;
        c.s_inc = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode/flag decoder producing the raw control bundle for a RUN-state instruction.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; stall, skip and stack-guard overrides are applied by the parent.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       s_z,
    input  logic       s_n,
    output ctrl_t      ctrl
);

    // Decode assumes I/O completes this cycle and the stack has room; parent overrides
    always_comb begin
        ctrl = ctrl_nop();
        if (!opcode[5]) begin
            ctrl.alu_vld = 1'b1;
            ctrl.op_alu  = opcode[4:2];
            ctrl.we3     = 1'b1;
            ctrl.wez     = 1'b1;
            ctrl.wen     = 1'b1;
        end else if (!opcode[4]) begin
            ctrl.s_inm = 1'b1;
            ctrl.we3   = 1'b1;
        end else begin
            case (opcode)
                OP_J:    ctrl.s_inc = 1'b0;
                OP_JZ:   ctrl.s_inc = ~s_z;
                OP_JNZ:  ctrl.s_inc = s_z;
                OP_JN:   ctrl.s_inc = ~s_n;
                OP_CALL: begin
                    ctrl.is_call = 1'b1;
                    ctrl.s_inc   = 1'b0;
                    ctrl.push    = 1'b1;
                    ctrl.wesp    = 1'b1;
                end
                OP_RET: begin
                    ctrl.is_ret = 1'b1;
                    ctrl.s_inc  = 1'b0;
                    ctrl.pop    = 1'b1;
                    ctrl.wesp   = 1'b1;
                end
                OP_SKZ:  ctrl.is_skip = s_z;
                OP_SKNZ: ctrl.is_skip = ~s_z;
                OP_IN: begin
                    ctrl.is_in = 1'b1;
                    ctrl.io_rd = 1'b1;
                    ctrl.s_in  = 1'b1;
                    ctrl.we3   = 1'b1;
                end
                OP_OUT: begin
                    ctrl.is_out = 1'b1;
                    ctrl.io_wr  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uc_seq.sv
// Sequenced control unit: opcode decode plus skip counter, stalling I/O handshake and call-depth guard.
// Latency: outputs combinational from state/opcode/flags; state and counters update on the next edge.
// Backpressure: io_ready low stalls the PC (pc_en=0) until ready or the optional timeout aborts.
module uc_seq
    import uc_pkg::*;
#(
    parameter int SKIP_LEN    = 1,
    parameter int STACK_DEPTH = 8,
    parameter int IO_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       s_z,
    input  logic       s_n,
    input  logic       io_ready,
    output logic       s_inc,
    output logic       s_inm,
    output logic       s_in,
    output logic       we3,
    output logic       wez,
    output logic       wen,
    output logic       wesp,
    output logic       push,
    output logic       pop,
    output logic       pc_en,
    output logic       io_rd,
    output logic       io_wr,
    output logic [2:0] op_alu,
    output logic       skipping,
    output logic       stk_ovf,
    output logic       stk_unf,
    output logic       io_timeout
);

    localparam int SKIP_W = (SKIP_LEN < 2)    ? 1 : $clog2(SKIP_LEN + 1);
    localparam int SP_W   = (STACK_DEPTH < 2) ? 1 : $clog2(STACK_DEPTH + 1);
    localparam int IO_W   = $clog2(IO_TIMEOUT + 2);

    localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP_LEN);
    localparam logic [SP_W-1:0]   SP_MAX    = SP_W'(STACK_DEPTH);
    localparam logic [IO_W-1:0]   IO_LIM    = IO_W'(IO_TIMEOUT);

    state_t            state;
    logic [SKIP_W-1:0] skip_cnt;
    logic [SP_W-1:0]   sp_cnt;
    logic [IO_W-1:0]   io_cnt;
    logic              io_is_in;
    logic [2:0]        op_alu_q;
    logic              stk_ovf_q;
    logic              stk_unf_q;
    logic              io_timeout_q;

    ctrl_t dec;
    ctrl_t oc;
    logic  pc_en_c;
    logic  skip_c;
    logic  io_stall;
    logic  io_abort;

    uc_decode u_decode (
        .opcode (opcode),
        .s_z    (s_z),
        .s_n    (s_n),
        .ctrl   (dec)
    );

    // Apply state-dependent suppression on top of the raw decode
    always_comb begin
        oc       = ctrl_nop();
        pc_en_c  = 1'b1;
        skip_c   = 1'b0;
        io_stall = 1'b0;
        io_abort = 1'b0;
        if (reset) begin
            oc      = '0;
            pc_en_c = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    oc = dec;
                    // Full stack: the call degrades to a NOP, is_call kept so the flag gets set
                    if (dec.is_call && (sp_cnt == SP_MAX)) begin
                        oc.push  = 1'b0;
                        oc.wesp  = 1'b0;
                        oc.s_inc = 1'b1;
                    end
                    if (dec.is_ret && (sp_cnt == '0)) begin
                        oc.pop   = 1'b0;
                        oc.wesp  = 1'b0;
                        oc.s_inc = 1'b1;
                    end
                    // Peripheral not ready: keep the request up, hold the PC, no write-back
                    if ((dec.is_in || dec.is_out) && !io_ready) begin
                        oc.we3   = 1'b0;
                        oc.s_in  = 1'b0;
                        pc_en_c  = 1'b0;
                        io_stall = 1'b1;
                    end
                end
                SKIP: skip_c = 1'b1;
                IO_WAIT: begin
                    oc.io_rd = io_is_in;
                    oc.io_wr = ~io_is_in;
                    pc_en_c  = 1'b0;
                    if (io_ready) begin
                        pc_en_c = 1'b1;
                        oc.s_in = io_is_in;
                        oc.we3  = io_is_in;
                    end else if ((IO_TIMEOUT > 0) && (io_cnt == IO_LIM)) begin
                        // Abort cycle drops the request and lets the PC move on
                        oc.io_rd = 1'b0;
                        oc.io_wr = 1'b0;
                        pc_en_c  = 1'b1;
                        io_abort = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM, skip/call-depth/I-O counters and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            skip_cnt     <= '0;
            sp_cnt       <= '0;
            io_cnt       <= '0;
            io_is_in     <= 1'b0;
            op_alu_q     <= 3'd0;
            stk_ovf_q    <= 1'b0;
            stk_unf_q    <= 1'b0;
            io_timeout_q <= 1'b0;
        end else begin
            if (oc.alu_vld) op_alu_q <= oc.op_alu;
            if (oc.is_call) begin
                if (oc.push) sp_cnt    <= sp_cnt + SP_W'(1);
                else         stk_ovf_q <= 1'b1;
            end
            if (oc.is_ret) begin
                if (oc.pop) sp_cnt    <= sp_cnt - SP_W'(1);
                else        stk_unf_q <= 1'b1;
            end
            case (state)
                RUN: begin
                    if (oc.is_skip && (SKIP_LEN > 0)) begin
                        state    <= SKIP;
                        skip_cnt <= SKIP_INIT;
                    end else if (io_stall) begin
                        state    <= IO_WAIT;
                        io_cnt   <= IO_W'(1);
                        io_is_in <= oc.is_in;
                    end
                end
                SKIP: begin
                    skip_cnt <= skip_cnt - SKIP_W'(1);
                    if (skip_cnt == SKIP_W'(1)) state <= RUN;
                end
                IO_WAIT: begin
                    if (io_ready) begin
                        state <= RUN;
                    end else if (io_abort) begin
                        io_timeout_q <= 1'b1;
                        state        <= RUN;
                    end else begin
                        io_cnt <= io_cnt + IO_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign s_inc      = oc.s_inc;
    assign s_inm      = oc.s_inm;
    assign s_in       = oc.s_in;
    assign we3        = oc.we3;
    assign wez        = oc.wez;
    assign wen        = oc.wen;
    assign wesp       = oc.wesp;
    assign push       = oc.push;
    assign pop        = oc.pop;
    assign io_rd      = oc.io_rd;
    assign io_wr      = oc.io_wr;
    assign pc_en      = pc_en_c;
    assign skipping   = skip_c;
    assign op_alu     = oc.alu_vld ? oc.op_alu : (reset ? 3'd0 : op_alu_q);
    assign stk_ovf    = stk_ovf_q    & ~reset;
    assign stk_unf    = stk_unf_q    & ~reset;
    assign io_timeout = io_timeout_q & ~reset;

endmodule
